// File: rtl/axi_dw_r_gatherer.sv
// rtl/axi_dw_r_gatherer.sv - packs narrow R beats into wide R beats for the downsizer read path
// One burst command at a time; lane/count follow the command, never nr_last_i.
module axi_dw_r_gatherer #(
  parameter int unsigned NarrowDataWidth = 32,
  parameter int unsigned WideDataWidth   = 64,
  parameter int unsigned IdWidth         = 4,
  parameter int unsigned UserWidth       = 1,
  parameter int unsigned Ratio           = WideDataWidth / NarrowDataWidth,
  parameter int unsigned LaneW           = (Ratio > 1) ? $clog2(Ratio) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [IdWidth-1:0]         cmd_id_i,
  input  logic [LaneW-1:0]           cmd_lane_i,
  input  logic [7:0]                 cmd_beats_i,
  input  logic                       nr_valid_i,
  output logic                       nr_ready_o,
  input  logic [NarrowDataWidth-1:0] nr_data_i,
  input  logic [1:0]                 nr_resp_i,
  input  logic                       nr_last_i,
  input  logic [UserWidth-1:0]       nr_user_i,
  output logic                       wr_valid_o,
  input  logic                       wr_ready_i,
  output logic [WideDataWidth-1:0]   wr_data_o,
  output logic [1:0]                 wr_resp_o,
  output logic                       wr_last_o,
  output logic [IdWidth-1:0]         wr_id_o,
  output logic [UserWidth-1:0]       wr_user_o,
  output logic                       proto_err_o
);

  localparam logic [LaneW-1:0] LastLane = LaneW'(Ratio - 1);

  typedef enum logic [1:0] {
    IDLE,
    GATHER,
    EMIT
  } state_e;

  state_e                     state_q, state_d;
  logic [WideDataWidth-1:0]   buf_q;
  logic [LaneW-1:0]           lane_q;
  logic [7:0]                 cnt_q;
  logic [1:0]                 resp_q;
  logic [UserWidth-1:0]       user_q;
  logic [IdWidth-1:0]         id_q;
  logic                       last_q;
  logic                       seen_q;
  logic                       proto_err_q;

  logic                       cmd_hs;
  logic                       nr_hs;
  logic                       wr_hs;
  logic                       beat_done;
  logic [1:0]                 resp_merged;

  assign cmd_hs    = cmd_valid_i & cmd_ready_o;
  assign nr_hs     = nr_valid_i & nr_ready_o;
  assign wr_hs     = wr_valid_o & wr_ready_i;
  assign beat_done = (lane_q == LastLane) || (cnt_q == 8'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // cmd_ready is gated by reset because IDLE is also the reset state.
  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    nr_ready_o  = 1'b0;
    wr_valid_o  = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_o = ~rst_i;
        if (cmd_valid_i && !rst_i) begin
          state_d = GATHER;
        end
      end
      GATHER: begin
        nr_ready_o = 1'b1;
        if (nr_valid_i && beat_done) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        wr_valid_o = 1'b1;
        if (wr_ready_i) begin
          state_d = last_q ? IDLE : GATHER;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // An error response sticks; otherwise EXOKAY survives only if every beat is EXOKAY.
  always_comb begin
    resp_merged = resp_q;
    if (!resp_q[1]) begin
      if (nr_resp_i[1] || !seen_q) begin
        resp_merged = nr_resp_i;
      end else begin
        resp_merged = {1'b0, resp_q[0] & nr_resp_i[0]};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_q       <= '0;
      lane_q      <= '0;
      cnt_q       <= '0;
      resp_q      <= '0;
      user_q      <= '0;
      id_q        <= '0;
      last_q      <= 1'b0;
      seen_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_hs) begin
            id_q   <= cmd_id_i;
            lane_q <= cmd_lane_i;
            cnt_q  <= cmd_beats_i;
            buf_q  <= '0;
            resp_q <= '0;
            user_q <= '0;
            seen_q <= 1'b0;
            last_q <= 1'b0;
          end
        end
        GATHER: begin
          if (nr_hs) begin
            buf_q[lane_q*NarrowDataWidth +: NarrowDataWidth] <= nr_data_i;
            resp_q      <= resp_merged;
            user_q      <= nr_user_i;
            seen_q      <= 1'b1;
            proto_err_q <= nr_last_i != (cnt_q == 8'd0);
            if (beat_done) begin
              last_q <= (cnt_q == 8'd0);
            end else begin
              lane_q <= lane_q + LaneW'(1);
              cnt_q  <= cnt_q - 8'd1;
            end
          end
        end
        EMIT: begin
          if (wr_hs && !last_q) begin
            buf_q  <= '0;
            resp_q <= '0;
            user_q <= '0;
            seen_q <= 1'b0;
            lane_q <= '0;
            cnt_q  <= cnt_q - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign wr_data_o   = buf_q;
  assign wr_resp_o   = resp_q;
  assign wr_last_o   = last_q;
  assign wr_id_o     = id_q;
  assign wr_user_o   = user_q;
  assign proto_err_o = proto_err_q;

endmodule
